dir_key_conditioner: RTL and testbench



---
 rtl/painter_pkg.sv | 20 ++
 rtl/dir_key_conditioner_if.sv | 12 +
 rtl/key_debounce.sv | 39 +++
 rtl/dir_key_conditioner.sv | 108 ++++++++++
 tb/tb_dir_key_conditioner.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/painter_pkg.sv
// rtl/painter_pkg.sv - shared types and constants for the direction key conditioner
package painter_pkg;

    localparam int NDIR      = 4;
    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    function automatic logic is_onehot(input logic [NDIR-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/dir_key_conditioner_if.sv
// rtl/dir_key_conditioner_if.sv - button input / step output bundle
interface dir_key_conditioner_if;

    logic [painter_pkg::NDIR-1:0] dir_raw;
    logic [painter_pkg::NDIR-1:0] step;
    logic [painter_pkg::NDIR-1:0] dir_db;
    logic                         repeating;

    modport master (output dir_raw, input step, input dir_db, input repeating);
    modport slave  (input dir_raw, output step, output dir_db, output repeating);

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser plus stable-count debouncer for one button
module key_debounce #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Any return to equality clears the count, so a bounce restarts the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dir_key_conditioner.sv
// rtl/dir_key_conditioner.sv - debounced direction buttons to one-hot step pulses with auto-repeat
module dir_key_conditioner
    import painter_pkg::*;
#(
    parameter int DB_CYCLES    = 1000000,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000,
    parameter int CNT_W        = 26
) (
    input logic                  clk,
    input logic                  rst,
    dir_key_conditioner_if.slave bus
);

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

    logic [NDIR-1:0]  dir_db;
    logic [NDIR-1:0]  dir_db_q;
    logic [NDIR-1:0]  rise;
    logic             fire;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic [NDIR-1:0]  cur_q, cur_d;
    logic [NDIR-1:0]  step_q, step_d;

    for (genvar i = 0; i < NDIR; i++) begin : g_db
        key_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (bus.dir_raw[i]),
            .level (dir_db[i])
        );
    end

    // Chords never move the cursor; only a new press leaving exactly one button down does.
    always_comb begin
        rise = dir_db & ~dir_db_q;
        fire = (rise != '0) && is_onehot(dir_db);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_db_q <= '0;
            state_q  <= IDLE;
            rcnt_q   <= '0;
            cur_q    <= '0;
            step_q   <= '0;
        end else begin
            dir_db_q <= dir_db;
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            cur_q    <= cur_d;
            step_q   <= step_d;
        end
    end

    // Abort is tested before the counter so a change of buttons beats a due pulse.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        cur_d   = cur_q;
        step_d  = '0;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    step_d  = dir_db;
                    cur_d   = dir_db;
                    rcnt_d  = '0;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (dir_db != cur_q) begin
                    state_d = IDLE;
                end else if (rcnt_q == RD_LAST) begin
                    step_d  = cur_q;
                    rcnt_d  = '0;
                    state_d = REPEAT;
                end else begin
                    rcnt_d = rcnt_q + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (dir_db != cur_q) begin
                    state_d = IDLE;
                end else if (rcnt_q == RR_LAST) begin
                    step_d = cur_q;
                    rcnt_d = '0;
                end else begin
                    rcnt_d = rcnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.step      = step_q;
        bus.dir_db    = dir_db;
        bus.repeating = (state_q == REPEAT);
    end

endmodule

// File: tb/tb_dir_key_conditioner.sv
// tb/tb_dir_key_conditioner.sv - scoreboard bench for dir_key_conditioner
module tb_dir_key_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 5;
    localparam int LAT = 2 + DB + 1;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic [3:0] prev_step = 4'b0;

    dir_key_conditioner_if bus ();

    dir_key_conditioner #(
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .CNT_W        (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    // Step monitor: every pulse must match the head of the queue in cycle and value.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (bus.step != 4'b0) begin
                check("step_onehot", {31'b0, $onehot(bus.step)}, 32'd1);
                if (prev_step != 4'b0) check("step_back_to_back", {28'b0, prev_step}, 32'd0);
                if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                    check("step_val", {28'b0, bus.step}, {28'b0, exp_q[0].val});
                    void'(exp_q.pop_front());
                end else begin
                    check("step_unexpected", {28'b0, bus.step}, 32'd0);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                check("step_missing", 32'd0, {28'b0, exp_q[0].val});
                void'(exp_q.pop_front());
            end
            prev_step = bus.step;
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t;
        bus.dir_raw = 4'b1000;

        // Reset held with a button down.
        for (int i = 1; i <= 3; i++) begin
            at_neg(i);
            check("rst_step", {28'b0, bus.step}, 32'd0);
            check("rst_dir_db", {28'b0, bus.dir_db}, 32'd0);
            check("rst_repeating", {31'b0, bus.repeating}, 32'd0);
        end
        goto(3);
        rst = 1'b0;
        push(3 + LAT, 4'b1000);
        at_neg(8);
        check("rel_dir_db_early", {28'b0, bus.dir_db}, 32'd0);
        at_neg(9);
        check("rel_dir_db", {28'b0, bus.dir_db}, 32'h8);
        goto(12);
        bus.dir_raw = 4'b0000;
        goto(25);

        // Bounce on right.
        n = cyc;
        bus.dir_raw = 4'b0001; goto(n + 1);
        bus.dir_raw = 4'b0000; goto(n + 2);
        bus.dir_raw = 4'b0001; goto(n + 3);
        bus.dir_raw = 4'b0001; goto(n + 4);
        bus.dir_raw = 4'b0000; goto(n + 5);
        bus.dir_raw = 4'b0001;
        push(n + 5 + LAT, 4'b0001);
        goto(n + 5 + LAT + 2);
        bus.dir_raw = 4'b0000;
        goto(cyc + 12);

        // Auto-repeat on left.
        n = cyc;
        t = n + LAT;
        bus.dir_raw = 4'b0010;
        push(t, 4'b0010);
        for (int k = RD; k <= 55; k += RR) push(t + k, 4'b0010);
        at_neg(t + 19);
        check("rep_before_delay", {31'b0, bus.repeating}, 32'd0);
        at_neg(t + 20);
        check("rep_after_delay", {31'b0, bus.repeating}, 32'd1);
        goto(t + 53);
        bus.dir_raw = 4'b0000;
        at_neg(t + 59);
        check("rep_db_released", {28'b0, bus.dir_db}, 32'd0);
        check("rep_still_repeating", {31'b0, bus.repeating}, 32'd1);
        at_neg(t + 60);
        check("rep_aborted", {31'b0, bus.repeating}, 32'd0);
        goto(t + 65);

        // Abort by adding a second button, then release paths.
        n = cyc;
        t = n + LAT;
        bus.dir_raw = 4'b1000;
        push(t, 4'b1000);
        goto(t + 4);
        bus.dir_raw = 4'b1001;
        at_neg(t + 10);
        check("abort_dir_db", {28'b0, bus.dir_db}, 32'h9);
        goto(t + 20);
        bus.dir_raw = 4'b0001;
        at_neg(t + 26);
        check("abort_release_up", {28'b0, bus.dir_db}, 32'h1);
        at_neg(t + 27);
        check("abort_not_repeating", {31'b0, bus.repeating}, 32'd0);
        goto(t + 30);
        bus.dir_raw = 4'b0000;
        goto(t + 40);
        bus.dir_raw = 4'b0001;
        push(t + 40 + LAT, 4'b0001);
        goto(t + 49);
        bus.dir_raw = 4'b0000;
        goto(t + 60);

        // Simultaneous press never steps.
        n = cyc;
        bus.dir_raw = 4'b0011;
        at_neg(n + 6);
        check("simul_dir_db", {28'b0, bus.dir_db}, 32'h3);
        goto(n + 30);
        bus.dir_raw = 4'b0000;
        at_neg(n + 36);
        check("simul_released", {28'b0, bus.dir_db}, 32'd0);
        goto(n + 40);

        // Reset during REPEAT with the button held through it.
        n = cyc;
        t = n + LAT;
        bus.dir_raw = 4'b0100;
        push(t, 4'b0100);
        push(t + RD, 4'b0100);
        at_neg(t + 21);
        check("rr_repeating", {31'b0, bus.repeating}, 32'd1);
        goto(t + 22);
        rst = 1'b1;
        at_neg(t + 23);
        check("rr_step", {28'b0, bus.step}, 32'd0);
        check("rr_repeating_clr", {31'b0, bus.repeating}, 32'd0);
        check("rr_dir_db_clr", {28'b0, bus.dir_db}, 32'd0);
        goto(t + 24);
        rst = 1'b0;
        push(t + 24 + LAT, 4'b0100);
        at_neg(t + 30);
        check("rr_redebounce", {28'b0, bus.dir_db}, 32'h4);
        goto(t + 33);
        bus.dir_raw = 4'b0000;
        goto(t + 45);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
